// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Bundles the instruction-fetch handshakes: the instruction-memory request /
//   response channel, the branch redirect from execute, and the instruction
//   stream toward decode.
//
//   master : the fetch stage (drives requests and the decode stream)
//   slave  : the environment (memory, execute, decode)
//
//   imem_req_valid/ready/addr   word-aligned fetch request
//   imem_resp_valid/data        returned instruction word
//   redirect_valid/base/imm     taken branch: target = base + sext(imm)*4
//   inst_valid/ready/data/pc    FIFO head toward decode
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_base;
    logic [15:0] redirect_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_base, redirect_imm,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_base, redirect_imm,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch for the 32-bit MIPS core. Owns the PC, keeps at most one
//   instruction-memory request outstanding, and buffers returned words in a
//   2-entry FIFO toward decode. A taken branch from execute reloads the PC,
//   flushes the FIFO and marks any in-flight request as stale.
//
//   Ports:
//     clk    clock, all state updates on posedge
//     rst_n  synchronous active-low reset
//     bus    fetch_stage_if.master (imem request/response, redirect, decode)
//   Parameter:
//     RESET_PC  PC loaded on reset
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_stage_if.master bus
);

    // REQ: may issue; WAIT: awaiting a live response; DROP: awaiting a stale one
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic [1:0]  count;
    logic        active;      // low for the cycle(s) in reset, keeps req low then

    // Shift-style FIFO: entry 0 is always the head, so the head outputs simply
    // hold their last value once the FIFO empties.
    logic [31:0] e0_data, e0_pc;
    logic [31:0] e1_data, e1_pc;

    logic        redirect;
    logic        accept;
    logic        resp;
    logic        push;
    logic        pop;
    logic [31:0] target;

    assign redirect = bus.redirect_valid;
    assign target   = bus.redirect_base + {{14{bus.redirect_imm[15]}}, bus.redirect_imm, 2'b00};

    // Request valid is built from registers only, never from inputs.
    assign bus.imem_req_valid = active && (state == S_REQ) && (count < 2'd2);
    assign bus.imem_req_addr  = pc;

    assign bus.inst_valid = (count != 2'd0);
    assign bus.inst_data  = e0_data;
    assign bus.inst_pc    = e0_pc;

    assign accept = bus.imem_req_valid && bus.imem_req_ready;
    // A response while in REQ is a protocol violation and is ignored.
    assign resp   = bus.imem_resp_valid && (state != S_REQ);
    assign push   = resp && (state == S_WAIT) && !redirect;
    assign pop    = bus.inst_valid && bus.inst_ready && !redirect;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            inflight_pc <= '0;
            count       <= '0;
            active      <= 1'b0;
        end else begin
            active <= 1'b1;

            case (state)
                // An accept that coincides with a redirect fetched a stale PC.
                S_REQ:   if (accept) state <= redirect ? S_DROP : S_WAIT;
                S_WAIT:  if (resp) state <= S_REQ;
                         else if (redirect) state <= S_DROP;
                S_DROP:  if (resp) state <= S_REQ;
                default: state <= S_REQ;
            endcase

            if (accept) inflight_pc <= pc;

            if (redirect)    pc <= target;
            else if (accept) pc <= pc + 32'd4;

            if (redirect) count <= '0;
            else          count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: FIFO storage is reset because the head outputs must read zero
    // after reset, not merely be flagged invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_data <= '0;
            e0_pc   <= '0;
            e1_data <= '0;
            e1_pc   <= '0;
        end else if (pop && (count == 2'd2)) begin
            e0_data <= e1_data;
            e0_pc   <= e1_pc;
            if (push) begin
                e1_data <= bus.imem_resp_data;
                e1_pc   <= inflight_pc;
            end
        end else if (push && ((count == 2'd0) || pop)) begin
            e0_data <= bus.imem_resp_data;
            e0_pc   <= inflight_pc;
        end else if (push) begin
            e1_data <= bus.imem_resp_data;
            e1_pc   <= inflight_pc;
        end
    end

endmodule
